keypad_scan_ctrl: RTL and testbench

//  Scan controller for the 3-column x 4-row keypad. Drives the column strobes, debounces the row

---
 rtl/keypad_pkg.sv | 79 +++++++
 rtl/scan_tick_gen.sv | 27 ++
 rtl/keypad_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, strobe codes and key map for the keypad scan controller
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2
    } kp_state_e;

    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    localparam logic [2:0] COL0 = 3'b100;
    localparam logic [2:0] COL1 = 3'b010;
    localparam logic [2:0] COL2 = 3'b001;

    // Phone-style layout: rows 0-2 carry digits 1-9, row 3 carries '*', '0', '#'.
    function automatic logic [3:0] kp_map(input logic [1:0] col, input logic [1:0] row);
        logic [3:0] code;
        case ({col, row})
            4'b00_00: code = 4'd1;
            4'b00_01: code = 4'd4;
            4'b00_10: code = 4'd7;
            4'b00_11: code = KEY_STAR;
            4'b01_00: code = 4'd2;
            4'b01_01: code = 4'd5;
            4'b01_10: code = 4'd8;
            4'b01_11: code = 4'd0;
            4'b10_00: code = 4'd3;
            4'b10_01: code = 4'd6;
            4'b10_10: code = 4'd9;
            4'b10_11: code = KEY_HASH;
            default:  code = 4'd0;
        endcase
        return code;
    endfunction

    function automatic logic row_onehot(input logic [3:0] rows);
        logic ok;
        case (rows)
            4'b1000, 4'b0100, 4'b0010, 4'b0001: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] rows);
        logic [1:0] idx;
        case (rows)
            4'b1000: idx = 2'd0;
            4'b0100: idx = 2'd1;
            4'b0010: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    function automatic logic [1:0] col_index(input logic [2:0] strobe);
        logic [1:0] idx;
        case (strobe)
            COL1:    idx = 2'd1;
            COL2:    idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Any corrupted strobe value recovers to column 0.
    function automatic logic [2:0] next_strobe(input logic [2:0] strobe);
        logic [2:0] nxt;
        case (strobe)
            COL0:    nxt = COL1;
            COL1:    nxt = COL2;
            default: nxt = COL0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - divides fin down to a one-cycle scan tick every SCAN_DIV cycles
module scan_tick_gen #(
    parameter int SCAN_DIV = 32768
) (
    input  logic fin,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge fin or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 3x4 keypad scanner with debounce and a valid/ready keycode buffer
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 32768,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       fin,
    input  logic       rst_n,
    input  logic [3:0] touch_key,
    output logic [2:0] scan_key,
    output logic [3:0] keycode,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] D_LAST = CW'(DEBOUNCE_SCANS - 1);

    logic            tick;
    kp_state_e       state, state_n;
    logic [2:0]      strobe_n;
    logic [1:0]      col_lat, col_n;
    logic [1:0]      row_lat, row_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [CW-1:0]   rel, rel_n;
    logic            accept;
    logic [3:0]      accept_code;
    logic            row_ok;
    logic [1:0]      cur_row;
    logic [1:0]      cur_col;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .fin   (fin),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign row_ok  = row_onehot(touch_key);
    assign cur_row = row_index(touch_key);
    assign cur_col = col_index(scan_key);

    always_comb begin
        state_n     = state;
        strobe_n    = scan_key;
        col_n       = col_lat;
        row_n       = row_lat;
        cnt_n       = cnt;
        rel_n       = rel;
        accept      = 1'b0;
        accept_code = kp_map(col_lat, row_lat);

        if (tick) begin
            case (state)
                SCAN: begin
                    if (row_ok) begin
                        col_n = cur_col;
                        row_n = cur_row;
                        if (DEBOUNCE_SCANS == 1) begin
                            accept      = 1'b1;
                            accept_code = kp_map(cur_col, cur_row);
                            rel_n       = '0;
                            state_n     = HELD;
                        end else begin
                            cnt_n   = CW'(1);
                            state_n = CONFIRM;
                        end
                    end else begin
                        strobe_n = next_strobe(scan_key);
                    end
                end
                CONFIRM: begin
                    if (row_ok && (cur_row == row_lat)) begin
                        if (cnt == D_LAST) begin
                            accept  = 1'b1;
                            cnt_n   = '0;
                            rel_n   = '0;
                            state_n = HELD;
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end else begin
                        cnt_n    = '0;
                        state_n  = SCAN;
                        strobe_n = next_strobe(scan_key);
                    end
                end
                HELD: begin
                    // Any row activity, even a multi-press, restarts the release count.
                    if (touch_key == 4'b0000) begin
                        if (rel == D_LAST) begin
                            rel_n    = '0;
                            state_n  = SCAN;
                            strobe_n = next_strobe(scan_key);
                        end else begin
                            rel_n = rel + CW'(1);
                        end
                    end else begin
                        rel_n = '0;
                    end
                end
                default: begin
                    state_n  = SCAN;
                    strobe_n = COL0;
                    cnt_n    = '0;
                    rel_n    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge fin or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            scan_key  <= COL0;
            col_lat   <= 2'd0;
            row_lat   <= 2'd0;
            cnt       <= '0;
            rel       <= '0;
            key_held  <= 1'b0;
            keycode   <= 4'd0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state    <= state_n;
            scan_key <= strobe_n;
            col_lat  <= col_n;
            row_lat  <= row_n;
            cnt      <= cnt_n;
            rel      <= rel_n;
            key_held <= (state_n == HELD);

            // A pending code is only replaced when it is consumed in the same cycle.
            if (accept && (!key_valid || key_ready)) begin
                keycode   <= accept_code;
                key_valid <= 1'b1;
            end else begin
                if (accept) begin
                    overrun <= 1'b1;
                end
                if (key_valid && key_ready) begin
                    key_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - directed table-driven bench for keypad_scan_ctrl
module tb_keypad_scan_ctrl;
    import keypad_pkg::*;

    logic       fin = 1'b0;
    logic       rst_n = 1'b0;
    always #5 fin = ~fin;

    logic [3:0] touch_key, touch_key1;
    logic [2:0] scan_key, scan_key1;
    logic [3:0] keycode, keycode1;
    logic       key_valid, key_valid1;
    logic       key_ready, key_ready1;
    logic       key_held, key_held1;
    logic       overrun, overrun1;

    // Keypad model: a pressed switch returns its rows only while its column is strobed.
    logic [2:0] press_col  = 3'b000;
    logic [3:0] press_rows = 4'b0000;
    logic [2:0] press_col1  = 3'b000;
    logic [3:0] press_rows1 = 4'b0000;

    assign touch_key  = (scan_key  == press_col)  ? press_rows  : 4'b0000;
    assign touch_key1 = (scan_key1 == press_col1) ? press_rows1 : 4'b0000;

    keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) u_dut (
        .fin       (fin),
        .rst_n     (rst_n),
        .touch_key (touch_key),
        .scan_key  (scan_key),
        .keycode   (keycode),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overrun   (overrun)
    );

    keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_SCANS(1)) u_dut1 (
        .fin       (fin),
        .rst_n     (rst_n),
        .touch_key (touch_key1),
        .scan_key  (scan_key1),
        .keycode   (keycode1),
        .key_valid (key_valid1),
        .key_ready (key_ready1),
        .key_held  (key_held1),
        .overrun   (overrun1)
    );

    int         hs_cnt = 0;
    int         hs_cnt1 = 0;
    logic [3:0] last_code = 4'hF;
    logic [3:0] last_code1 = 4'hF;

    always @(posedge fin) begin
        if (key_valid && key_ready) begin
            hs_cnt    = hs_cnt + 1;
            last_code = keycode;
        end
        if (key_valid1 && key_ready1) begin
            hs_cnt1    = hs_cnt1 + 1;
            last_code1 = keycode1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Returns just after the clock edge on which a scan tick was sampled.
    task automatic next_tick();
        int n;
        n = 0;
        @(negedge fin);
        while (u_dut.tick !== 1'b1 && n < 16) begin
            @(negedge fin);
            n++;
        end
        if (u_dut.tick !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout actual=0 required=1");
        end
        @(posedge fin);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) next_tick();
    endtask

    typedef struct {
        logic [2:0] col;
        logic [3:0] rows;
        logic [3:0] code;
    } key_vec_t;

    key_vec_t vecs[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rot;
        int seen;
        logic [2:0] prev;

        vecs[0]  = '{COL0, 4'b1000, 4'd1};
        vecs[1]  = '{COL1, 4'b1000, 4'd2};
        vecs[2]  = '{COL2, 4'b1000, 4'd3};
        vecs[3]  = '{COL0, 4'b0100, 4'd4};
        vecs[4]  = '{COL1, 4'b0100, 4'd5};
        vecs[5]  = '{COL2, 4'b0100, 4'd6};
        vecs[6]  = '{COL0, 4'b0010, 4'd7};
        vecs[7]  = '{COL1, 4'b0010, 4'd8};
        vecs[8]  = '{COL2, 4'b0010, 4'd9};
        vecs[9]  = '{COL0, 4'b0001, 4'd10};
        vecs[10] = '{COL1, 4'b0001, 4'd0};
        vecs[11] = '{COL2, 4'b0001, 4'd11};

        key_ready  = 1'b1;
        key_ready1 = 1'b1;
        rst_n      = 1'b0;
        repeat (3) @(posedge fin);
        #1;
        check("rst_scan_key", scan_key, 3'b100);
        check("rst_keycode", keycode, 4'd0);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_held", key_held, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        @(negedge fin);
        rst_n = 1'b1;

        // Key '5': col1 row1, held through debounce then released.
        base = hs_cnt;
        press_col  = COL1;
        press_rows = 4'b0100;
        next_tick();
        check("k5_rotate_to_col1", scan_key, 3'b010);
        check("k5_no_valid_t1", key_valid, 1'b0);
        next_tick();
        check("k5_frozen_t2", scan_key, 3'b010);
        next_tick();
        check("k5_no_valid_t3", key_valid, 1'b0);
        next_tick();
        check("k5_valid", key_valid, 1'b1);
        check("k5_code", keycode, 4'd5);
        check("k5_held", key_held, 1'b1);
        @(posedge fin);
        #1;
        check("k5_valid_drop", key_valid, 1'b0);
        ticks(3);
        check("k5_held_on", key_held, 1'b1);
        check("k5_frozen_held", scan_key, 3'b010);
        check("k5_single_pulse", hs_cnt - base, 1);
        press_col = 3'b000;
        ticks(2);
        check("k5_held_rel2", key_held, 1'b1);
        next_tick();
        check("k5_released", key_held, 1'b0);
        check("k5_resume_col2", scan_key, 3'b001);

        // Bounce: row0 under col2 for two ticks only.
        base = hs_cnt;
        press_col  = COL2;
        press_rows = 4'b1000;
        ticks(2);
        check("bounce_frozen", scan_key, 3'b001);
        press_col = 3'b000;
        next_tick();
        check("bounce_resume_col0", scan_key, 3'b100);
        ticks(3);
        check("bounce_no_key", hs_cnt - base, 0);

        // All twelve keys in turn.
        foreach (vecs[i]) begin
            base = hs_cnt;
            press_col  = vecs[i].col;
            press_rows = vecs[i].rows;
            ticks(8);
            press_col = 3'b000;
            ticks(5);
            check($sformatf("key%0d_count", i), hs_cnt - base, 1);
            check($sformatf("key%0d_code", i), last_code, vecs[i].code);
        end

        // Consumer stalled: '7' then '#'.
        key_ready = 1'b0;
        base = hs_cnt;
        press_col = COL0; press_rows = 4'b0010;
        ticks(8);
        press_col = 3'b000;
        ticks(5);
        press_col = COL2; press_rows = 4'b0001;
        ticks(8);
        press_col = 3'b000;
        ticks(5);
        check("ovr_code_kept", keycode, 4'd7);
        check("ovr_valid", key_valid, 1'b1);
        check("ovr_flag", overrun, 1'b1);
        @(negedge fin);
        key_ready = 1'b1;
        @(posedge fin);
        #1;
        check("ovr_valid_drop", key_valid, 1'b0);
        repeat (6) @(posedge fin);
        #1;
        check("ovr_one_handshake", hs_cnt - base, 1);
        check("ovr_last_code", last_code, 4'd7);
        check("ovr_sticky", overrun, 1'b1);

        // Reset while '9' is held and its code is pending.
        key_ready = 1'b0;
        press_col = COL2; press_rows = 4'b0010;
        ticks(7);
        check("mid_valid", key_valid, 1'b1);
        check("mid_code", keycode, 4'd9);
        @(posedge fin);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_scan_key", scan_key, 3'b100);
        check("async_key_valid", key_valid, 1'b0);
        check("async_keycode", keycode, 4'd0);
        check("async_overrun", overrun, 1'b0);
        check("async_key_held", key_held, 1'b0);
        @(negedge fin);
        rst_n = 1'b1;
        key_ready = 1'b1;
        base = hs_cnt;
        ticks(8);
        check("redetect_count", hs_cnt - base, 1);
        check("redetect_code", last_code, 4'd9);
        press_col = 3'b000;
        ticks(5);

        // Two rows together under col0: ignored, scan keeps rotating.
        base = hs_cnt;
        press_col = COL0; press_rows = 4'b1100;
        prev = scan_key;
        rot = 0;
        for (int i = 0; i < 10; i++) begin
            next_tick();
            if (scan_key != prev) rot++;
            prev = scan_key;
        end
        check("multi_rotates", rot, 10);
        check("multi_no_key", hs_cnt - base, 0);
        check("multi_not_held", key_held, 1'b0);
        press_col = 3'b000;

        // Single-sample debounce: key '0' accepted on its first valid tick.
        base = hs_cnt1;
        press_col1 = COL1; press_rows1 = 4'b0001;
        seen = 0;
        for (int i = 0; i < 4 && seen == 0; i++) begin
            if (touch_key1 != 4'b0000) begin
                next_tick();
                seen = 1;
                check("d1_valid", key_valid1, 1'b1);
                check("d1_code", keycode1, 4'd0);
                check("d1_held", key_held1, 1'b1);
            end else begin
                next_tick();
                check($sformatf("d1_no_early_%0d", i), key_valid1, 1'b0);
            end
        end
        check("d1_detected", seen, 1);
        @(posedge fin);
        #1;
        check("d1_valid_drop", key_valid1, 1'b0);
        press_col1 = 3'b000;
        next_tick();
        check("d1_released", key_held1, 1'b0);
        check("d1_count", hs_cnt1 - base, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
